shift_reg_burst: RTL and testbench

- Parametrised multi-bit successor to the single-bit flip-flop primitive.
- WIDTH-bit register with asynchronous clear and asynchronous preset to a parametrised value.
- Clock-enabled direct modes: hold, parallel load, shift, rotate, arithmetic shift, invert.
- Burst engine applies a latched op N times with busy/done handshake; used for serialisers, LFSR seeding and bit-manipulation datapaths.

---
 rtl/shift_reg_burst.sv | 172 +++++++++++++++++
 tb/tb_shift_reg_burst.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_burst.sv
// shift_reg_burst
//   WIDTH-bit register with asynchronous clear (clr) and asynchronous preset
//   (pre, to PRESET_VAL). It offers clock-enabled direct ops and a burst
//   engine that repeats a latched op 'count' times.
//
//   Ports:
//     clk            rising-edge clock
//     clr            async clear, active high, highest priority
//     pre            async preset to PRESET_VAL, active high
//     en             clock enable for direct ops and burst steps
//     mode[2:0]      000 hold, 001 load, 010 shl, 011 shr, 100 rol,
//                    101 ror, 110 asr, 111 invert
//     d[WIDTH-1:0]   parallel load data
//     sin            serial input for logical shifts (sampled live in bursts)
//     start          begin burst (IDLE with en=1 only)
//     count[CNT_W-1:0] burst repeat count, sampled with start
//     q[WIDTH-1:0]   register contents
//     sout_l, sout_r q[WIDTH-1] and q[0]
//     busy           high while a burst is running
//     done           one-cycle pulse when a burst completes
//     q_shadow       (only with SHIFT_REG_BURST_SHADOW_EN) post-burst snapshot
//
//   Handshake: start is accepted in IDLE when en=1. busy stays high in RUN.
//   done is high for exactly the one cycle spent in DONE. All inputs are
//   ignored in DONE. An async clr/pre aborts a burst and produces no done.
//
//   Optional feature macro: SHIFT_REG_BURST_SHADOW_EN
module shift_reg_burst #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter int               CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
`ifdef SHIFT_REG_BURST_SHADOW_EN
  output logic [WIDTH-1:0] q_shadow,
`endif
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // state is the FSM observation point for checkers
  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] rem, rem_next;
  logic [2:0]       op_lat, op_lat_next;
  logic [WIDTH-1:0] d_lat, d_lat_next;
`ifdef SHIFT_REG_BURST_SHADOW_EN
  logic [WIDTH-1:0] shadow_reg;
`endif

  // One application of an op. Undefined encodings cannot occur with 3 bits,
  // but the default still holds so no X reaches q.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] ld,
                                                input logic s);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = cur;
      3'b001:  r = ld;
      3'b010:  r = {cur[WIDTH-2:0], s};
      3'b011:  r = {s, cur[WIDTH-1:1]};
      3'b100:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  r = {cur[0], cur[WIDTH-1:1]};
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111:  r = ~cur;
      default: r = cur;
    endcase
    return r;
  endfunction

  // State register plus datapath registers
  always_ff @(posedge clk or posedge clr or posedge pre) begin
    if (clr) begin
      state  <= IDLE;
      q_reg  <= '0;
      rem    <= '0;
      op_lat <= '0;
      d_lat  <= '0;
`ifdef SHIFT_REG_BURST_SHADOW_EN
      shadow_reg <= '0;
`endif
    end else if (pre) begin
      state  <= IDLE;
      q_reg  <= PRESET_VAL;
      rem    <= '0;
      op_lat <= '0;
      d_lat  <= '0;
`ifdef SHIFT_REG_BURST_SHADOW_EN
      shadow_reg <= PRESET_VAL;
`endif
    end else begin
      state  <= state_next;
      q_reg  <= q_next;
      rem    <= rem_next;
      op_lat <= op_lat_next;
      d_lat  <= d_lat_next;
`ifdef SHIFT_REG_BURST_SHADOW_EN
      // Snapshot on the edge that enters DONE, so it matches q while done=1
      if (state_next == DONE && state != DONE) shadow_reg <= q_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en && start) state_next = (count == '0) ? DONE : RUN;
      RUN:     if (en && rem == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    q_next      = q_reg;
    rem_next    = rem;
    op_lat_next = op_lat;
    d_lat_next  = d_lat;
    case (state)
      IDLE: begin
        if (en) begin
          if (start) begin
            // Capture the burst; q is untouched on the start edge
            op_lat_next = mode;
            d_lat_next  = d;
            rem_next    = count;
          end else begin
            q_next = apply_op(mode, q_reg, d, sin);
          end
        end
      end
      RUN: begin
        if (en) begin
          q_next   = apply_op(op_lat, q_reg, d_lat, sin);
          rem_next = rem - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs. The pre override covers the window where clr falls while pre is
  // still high: the register itself picks up PRESET_VAL on the next clock
  // edge that sees pre high.
  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    q      = (pre && !clr) ? PRESET_VAL : q_reg;
    sout_l = q[WIDTH-1];
    sout_r = q[0];
`ifdef SHIFT_REG_BURST_SHADOW_EN
    q_shadow = (pre && !clr) ? PRESET_VAL : shadow_reg;
`endif
  end

endmodule

// File: tb/tb_shift_reg_burst.sv
// Testbench for shift_reg_burst (WIDTH=8). Define SHIFT_REG_BURST_SHADOW_EN
// for both files to include the q_shadow scenario.
module tb_shift_reg_burst;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          pre = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          sin = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [W-1:0]  d = '0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  q;
  logic          sout_l, sout_r, busy, done;
`ifdef SHIFT_REG_BURST_SHADOW_EN
  logic [W-1:0]  q_shadow;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q_m;   // reference value of the register

  shift_reg_burst #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .count(count), .q(q),
`ifdef SHIFT_REG_BURST_SHADOW_EN
    .q_shadow(q_shadow),
`endif
    .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference op: arithmetic on integers rather than bit slicing
  function automatic logic [W-1:0] model_op(input int op, input int cur, input int ld, input int s);
    int m, top, r;
    m = (1 << W) - 1;
    top = 1 << (W - 1);
    case (op)
      0: r = cur;
      1: r = ld;
      2: r = cur * 2 + s;
      3: r = cur / 2 + s * top;
      4: r = cur * 2 + cur / top;
      5: r = cur / 2 + (cur % 2) * top;
      6: r = cur / 2 + (cur & top);
      7: r = m - cur;
      default: r = cur;
    endcase
    return W'(r & m);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one direct op, updates the model
  task automatic drive_direct(input logic [2:0] m, input logic [W-1:0] dv, input logic s, input logic e);
    mode = m; d = dv; sin = s; en = e; start = 1'b0;
    step();
    if (e) q_m = model_op(int'(m), int'(q_m), int'(dv), int'(s));
    en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
    clr = 1'b0;
    q_m = '0;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_hold got=%h exp=00", q); end
  endtask

  task automatic test_async_priority();
    drive_direct(3'b001, 8'hA5, 1'b0, 1'b1);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL async_setup got=%h exp=a5", q); end
    #2 pre = 1'b1;
    #1;
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL async_pre got=%h exp=ff", q); end
    clr = 1'b1;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL async_clr_wins got=%h exp=00", q); end
    clr = 1'b0;
    #1;
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL async_clr_release got=%h exp=ff", q); end
    step();
    pre = 1'b0;
    #1;
    checks++; if (q !== 8'hFF || busy !== 1'b0) begin errors++; $display("FAIL async_pre_release q=%h busy=%b exp=ff/0", q, busy); end
    q_m = 8'hFF;
  endtask

  task automatic test_direct_ops();
    logic [2:0]   t_mode [6];
    logic [W-1:0] t_d    [6];
    logic         t_sin  [6];
    logic         t_en   [6];
    logic [W-1:0] t_exp  [6];
    t_mode = '{3'b001, 3'b100, 3'b011, 3'b110, 3'b111, 3'b001};
    t_d    = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
    t_sin  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t_exp  = '{8'h81, 8'h03, 8'h81, 8'hC0, 8'h3F, 8'h3F};
    for (int i = 0; i < 6; i++) begin
      drive_direct(t_mode[i], t_d[i], t_sin[i], t_en[i]);
      checks++; if (q !== t_exp[i]) begin errors++; $display("FAIL direct_row%0d got=%h exp=%h", i, q, t_exp[i]); end
    end
    for (int i = 0; i < 60; i++) begin
      drive_direct(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      checks++; if (q !== q_m) begin errors++; $display("FAIL direct_rand%0d got=%h exp=%h", i, q, q_m); end
      checks++; if (sout_l !== q_m[W-1] || sout_r !== q_m[0]) begin errors++; $display("FAIL sout_rand%0d got=%b%b exp=%b%b", i, sout_l, sout_r, q_m[W-1], q_m[0]); end
    end
  endtask

  task automatic test_burst();
    drive_direct(3'b001, 8'h01, 1'b0, 1'b1);
    mode = 3'b010; count = CW'(3); sin = 1'b0; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0; mode = 3'b111; d = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL burst_busy%0d busy=%b done=%b exp=1/0", i, busy, done); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h08) begin errors++; $display("FAIL burst_done done=%b busy=%b q=%h exp=1/0/08", done, busy, q); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL burst_idle done=%b busy=%b exp=0/0", done, busy); end
    en = 1'b0;
    q_m = 8'h08;
  endtask

  task automatic test_stall_and_zero();
    drive_direct(3'b001, 8'h01, 1'b0, 1'b1);
    mode = 3'b101; count = CW'(2); en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if (q !== 8'h80 || busy !== 1'b1) begin errors++; $display("FAIL stall_step1 q=%h busy=%b exp=80/1", q, busy); end
    en = 1'b0;
    step();
    checks++; if (q !== 8'h80 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stall_hold q=%h busy=%b done=%b exp=80/1/0", q, busy, done); end
    en = 1'b1;
    step();
    checks++; if (q !== 8'h40 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_done q=%h done=%b busy=%b exp=40/1/0", q, done, busy); end
    step();
    // count = 0 goes straight to DONE
    mode = 3'b111; count = '0; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h40) begin errors++; $display("FAIL zero_done done=%b busy=%b q=%h exp=1/0/40", done, busy, q); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h40) begin errors++; $display("FAIL zero_after done=%b busy=%b q=%h exp=0/0/40", done, busy, q); end
    en = 1'b0;
    q_m = 8'h40;
  endtask

  task automatic test_abort();
    drive_direct(3'b001, 8'h3C, 1'b0, 1'b1);
    mode = 3'b100; count = CW'(5); en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (q !== 8'hF0 || busy !== 1'b1) begin errors++; $display("FAIL abort_mid q=%h busy=%b exp=f0/1", q, busy); end
    #2 pre = 1'b1;
    #1;
    checks++; if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_pre q=%h busy=%b done=%b exp=ff/0/0", q, busy, done); end
    pre = 1'b0;
    mode = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'hFF) begin errors++; $display("FAIL abort_quiet%0d done=%b busy=%b q=%h exp=0/0/ff", i, done, busy, q); end
    end
    mode = 3'b010; sin = 1'b0; count = CW'(1); start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart busy=%b exp=1", busy); end
    step();
    checks++; if (done !== 1'b1 || q !== 8'hFE) begin errors++; $display("FAIL abort_restart_done done=%b q=%h exp=1/fe", done, q); end
    step();
    en = 1'b0;
    q_m = 8'hFE;
  endtask

  task automatic test_random_bursts();
    for (int b = 0; b < 14; b++) begin
      logic [2:0]   bm;
      logic [W-1:0] bd;
      int           remaining, cyc;
      logic         e, s;
      bm = 3'($urandom_range(0, 7));
      bd = W'($urandom);
      remaining = (b == 0) ? 15 : ((b == 1) ? 0 : $urandom_range(0, 15));
      drive_direct(3'b001, W'($urandom), 1'b0, 1'b1);
      mode = bm; d = bd; count = CW'(remaining); en = 1'b1; start = 1'b1;
      step();
      cyc = 0;
      while (remaining > 0 && cyc < 100) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rb%0d_busy busy=%b done=%b exp=1/0", b, busy, done); end
        e = ($urandom_range(0, 3) != 0);
        s = 1'($urandom);
        en = e; sin = s; start = 1'($urandom);
        mode = 3'($urandom); d = W'($urandom); count = CW'($urandom);
        step();
        if (e) begin
          q_m = model_op(int'(bm), int'(q_m), int'(bd), int'(s));
          remaining--;
        end
        cyc++;
      end
      if (remaining > 0) begin
        checks++; errors++; $display("FAIL rb%0d_timeout remaining=%0d exp=0", b, remaining);
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== q_m) begin errors++; $display("FAIL rb%0d_done done=%b busy=%b q=%h exp=1/0/%h", b, done, busy, q, q_m); end
      // DONE ignores everything, even an enabled start
      en = 1'b1; start = 1'b1; mode = 3'b111;
      step();
      start = 1'b0; en = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== q_m) begin errors++; $display("FAIL rb%0d_after done=%b busy=%b q=%h exp=0/0/%h", b, done, busy, q, q_m); end
    end
  endtask

`ifdef SHIFT_REG_BURST_SHADOW_EN
  task automatic test_shadow();
    drive_direct(3'b001, 8'h12, 1'b0, 1'b1);
    mode = 3'b100; count = CW'(4); en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (done !== 1'b1 || q_shadow !== 8'h21 || q !== 8'h21) begin errors++; $display("FAIL shadow_done done=%b sh=%h q=%h exp=1/21/21", done, q_shadow, q); end
    step();
    drive_direct(3'b001, 8'h00, 1'b0, 1'b1);
    checks++; if (q_shadow !== 8'h21 || q !== 8'h00) begin errors++; $display("FAIL shadow_hold sh=%h q=%h exp=21/00", q_shadow, q); end
    #2 clr = 1'b1;
    #1;
    checks++; if (q_shadow !== 8'h00) begin errors++; $display("FAIL shadow_clr sh=%h exp=00", q_shadow); end
    clr = 1'b0;
    #1 pre = 1'b1;
    #1;
    checks++; if (q_shadow !== 8'hFF) begin errors++; $display("FAIL shadow_pre sh=%h exp=ff", q_shadow); end
    pre = 1'b0;
    step();
    q_m = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_async_priority();
    test_direct_ops();
    test_burst();
    test_stall_and_zero();
    test_abort();
    test_random_bursts();
`ifdef SHIFT_REG_BURST_SHADOW_EN
    test_shadow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
